// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencing FSM for an RV32I core (FETCH/DECODE/EXECUTE/MEM/WB/HALT/FAULT).
// Ports: clk/reset (sync, active-high); instruction + imem/dmem ready + branch_taken in;
//        fetch/IR/PC/ALU/regfile/dmem strobes, imm_type, halted, fault and debug state out.
// Optional: `ILLEGAL_TRAP_EN sends unrecognised or non-32-bit opcodes to FAULT; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_type,
  output logic        alu_src_imm,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;
  localparam logic [2:0] S_FAULT   = 3'd6;

  localparam logic [3:0] C_OP      = 4'd0;
  localparam logic [3:0] C_OPIMM   = 4'd1;
  localparam logic [3:0] C_LOAD    = 4'd2;
  localparam logic [3:0] C_STORE   = 4'd3;
  localparam logic [3:0] C_BRANCH  = 4'd4;
  localparam logic [3:0] C_JAL     = 4'd5;
  localparam logic [3:0] C_JALR    = 4'd6;
  localparam logic [3:0] C_UPPER   = 4'd7;
  localparam logic [3:0] C_FENCE   = 4'd8;
  localparam logic [3:0] C_SYSTEM  = 4'd9;
  localparam logic [3:0] C_ILLEGAL = 4'd10;

  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_I     = 3'd1;
  localparam logic [2:0] IMM_SHAMT = 3'd2;
  localparam logic [2:0] IMM_S     = 3'd3;
  localparam logic [2:0] IMM_B     = 3'd4;
  localparam logic [2:0] IMM_U     = 3'd5;
  localparam logic [2:0] IMM_J     = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cls_q, cls_d;
  logic [2:0]    imm_q, imm_d;

  // Opcode classification; only captured on the DECODE edge.
  always_comb begin
    cls_d = C_ILLEGAL;
    imm_d = IMM_NONE;
    case (instruction[6:2])
      5'b00000: begin cls_d = C_LOAD;   imm_d = IMM_I; end
      5'b00100: begin
        cls_d = C_OPIMM;
        imm_d = (instruction[14:12] == 3'b001 || instruction[14:12] == 3'b101) ? IMM_SHAMT : IMM_I;
      end
      5'b11001: begin cls_d = C_JALR;   imm_d = IMM_I; end
      5'b01000: begin cls_d = C_STORE;  imm_d = IMM_S; end
      5'b11000: begin cls_d = C_BRANCH; imm_d = IMM_B; end
      5'b01101,
      5'b00101: begin cls_d = C_UPPER;  imm_d = IMM_U; end
      5'b11011: begin cls_d = C_JAL;    imm_d = IMM_J; end
      5'b01100: cls_d = C_OP;
      5'b00011: cls_d = C_FENCE;
      5'b11100: cls_d = C_SYSTEM;
      default:  cls_d = C_ILLEGAL;
    endcase
    // Compressed / non-32-bit encodings are never valid here.
    if (instruction[1:0] != 2'b11) begin
      cls_d = C_ILLEGAL;
      imm_d = IMM_NONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;       // cleared on every transition; waiting states override
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    rf_wsel     = 2'd0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Timeout is checked before ready so the request is dropped on the expiring cycle.
        if (cnt_q == TMO) begin
          state_d = S_FAULT;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DECODE: begin
        if (cls_d == C_SYSTEM) begin
          state_d = S_HALT;
        end else if (cls_d == C_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_FAULT;
`else
          state_d = S_EXECUTE;
`endif
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_src_imm = !(cls_q == C_OP || cls_q == C_BRANCH);
        case (cls_q)
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          C_FENCE, C_ILLEGAL: begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cnt_q == TMO) begin
          state_d = S_FAULT;
        end else begin
          dmem_re = (cls_q == C_LOAD);
          dmem_we = (cls_q != C_LOAD);
          if (dmem_ready) begin
            if (cls_q == C_LOAD) begin
              state_d = S_WB;
            end else begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WB: begin
        rf_we = (instruction[11:7] != 5'd0);
        pc_we = 1'b1;
        case (cls_q)
          C_LOAD:  rf_wsel = 2'd1;
          C_JAL:   begin rf_wsel = 2'd2; pc_src = 2'd2; end
          C_JALR:  begin rf_wsel = 2'd2; pc_src = 2'd3; end
          default: rf_wsel = 2'd0;
        endcase
        state_d = S_FETCH;
      end
      S_HALT, S_FAULT: state_d = state_q;
      default:         state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cls_q   <= C_OP;
      imm_q   <= IMM_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Class and immediate format stay frozen from DECODE through WB.
      if (state_q == S_DECODE) begin
        cls_q <= cls_d;
        imm_q <= imm_d;
      end
    end
  end

  assign imm_type = imm_q;
  assign halted   = (state_q == S_HALT);
  assign fault    = (state_q == S_FAULT);
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed RV32I instructions followed by random ones, each checked
// against per-instruction totals (cycles, strobe counts, selects) derived from the instruction rules.
module tb_multicycle_ctrl;

  localparam int TMO = 15;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0000_0013;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, ir_we, pc_we, alu_src_imm, rf_we, dmem_re, dmem_we, halted, fault;
  logic [1:0]  pc_src, rf_wsel;
  logic [2:0]  imm_type, state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .imm_type(imm_type), .alu_src_imm(alu_src_imm), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .halted(halted), .fault(fault), .state(state)
  );

  int total = 0;
  int bad = 0;

  // Per-instruction observations
  int n_cyc, n_pcwe, n_rfwe, n_re, n_we, n_irwe, n_alu, n_irbad;
  logic [1:0] o_pcsrc, o_wsel;
  logic [2:0] o_imm;
  logic saw_halt, saw_fault;
  int fcnt, mcnt, fwait, mwait;

  logic [4:0] ops [0:13] = '{5'd0, 5'd4, 5'd25, 5'd8, 5'd24, 5'd13, 5'd5,
                             5'd27, 5'd12, 5'd3, 5'd28, 5'd31, 5'd2, 5'd10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: memories answer after fwait/mwait request cycles; dmem_ready outside MEM is noise.
  task automatic tick();
    @(negedge clk);
    reset = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    if (imem_req === 1'b1) begin
      if (fcnt == fwait) imem_ready = 1'b1;
      fcnt++;
    end
    if (dmem_re === 1'b1 || dmem_we === 1'b1) begin
      if (mcnt == mwait) dmem_ready = 1'b1;
      mcnt++;
    end else if (state !== 3'd3) begin
      dmem_ready = 1'($urandom_range(0, 1));
    end
    #1;
    if (halted === 1'b1 || fault === 1'b1) begin
      saw_halt  = halted;
      saw_fault = fault;
    end else begin
      n_cyc++;
      if (pc_we === 1'b1) begin n_pcwe++; o_pcsrc = pc_src; o_imm = imm_type; end
      if (rf_we === 1'b1) begin n_rfwe++; o_wsel = rf_wsel; end
      if (dmem_re === 1'b1) n_re++;
      if (dmem_we === 1'b1) n_we++;
      if (ir_we === 1'b1) n_irwe++;
      if (ir_we === 1'b1 && imem_req !== 1'b1) n_irbad++;
      if (alu_src_imm === 1'b1) n_alu++;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ":rst_state"}, 32'(state), 0);
    chk({tag, ":rst_flags"}, {halted, fault}, 0);
    chk({tag, ":rst_imem_req"}, 32'(imem_req), 1);
    chk({tag, ":rst_strobes"}, {ir_we, pc_we, alu_src_imm, rf_we, dmem_re, dmem_we}, 0);
    chk({tag, ":rst_sel"}, {pc_src, rf_wsel, imm_type}, 0);
  endtask

  task automatic run_instr(input string name, input logic [31:0] ins, input int fw, input int mw,
                           input logic tk);
    logic [4:0] op;
    int e_cyc, e_pcwe, e_rfwe, e_re, e_we, e_irwe, e_alu;
    logic [1:0] e_pcsrc, e_wsel;
    logic [2:0] e_imm;
    logic e_halt, e_fault, done, rd_nz, is_ill;
    op = ins[6:2];
    rd_nz = (ins[11:7] != 5'd0);
    instruction = ins; branch_taken = tk; fwait = fw; mwait = mw; fcnt = 0; mcnt = 0;
    n_cyc = 0; n_pcwe = 0; n_rfwe = 0; n_re = 0; n_we = 0; n_irwe = 0; n_alu = 0; n_irbad = 0;
    o_pcsrc = 2'd0; o_wsel = 2'd0; o_imm = 3'd0; saw_halt = 1'b0; saw_fault = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (n_pcwe > 0 || saw_halt || saw_fault) done = 1'b1;
    end
    chk({name, ":finished"}, 32'(done), 1);

    // Reference: totals per instruction from the opcode rules.
    e_pcwe = 0; e_rfwe = 0; e_re = 0; e_we = 0; e_alu = 0; e_irwe = 1;
    e_pcsrc = 2'd0; e_wsel = 2'd0; e_imm = 3'd0; e_halt = 1'b0; e_fault = 1'b0;
    is_ill = !(op inside {5'd0, 5'd4, 5'd25, 5'd8, 5'd24, 5'd13, 5'd5, 5'd27, 5'd12, 5'd3, 5'd28})
             || ins[1:0] != 2'b11;
    if (fw >= TMO) begin
      e_cyc = TMO + 1; e_irwe = 0; e_fault = 1'b1;
    end else if (is_ill && TRAP) begin
      e_cyc = fw + 2; e_fault = 1'b1;
    end else if (is_ill || op == 5'd3 || op == 5'd24) begin
      e_cyc = fw + 3; e_pcwe = 1;
      e_pcsrc = (op == 5'd24 && !is_ill && tk) ? 2'd1 : 2'd0;
      e_alu = (op == 5'd24 && !is_ill) ? 0 : 1;
      e_imm = (op == 5'd24 && !is_ill) ? 3'd4 : 3'd0;
    end else if (op == 5'd28) begin
      e_cyc = fw + 2; e_halt = 1'b1;
    end else if (op == 5'd0 || op == 5'd8) begin
      e_alu = 1; e_imm = (op == 5'd0) ? 3'd1 : 3'd3;
      if (mw >= TMO) begin
        e_cyc = fw + 3 + TMO + 1; e_fault = 1'b1;
        if (op == 5'd0) e_re = TMO; else e_we = TMO;
      end else if (op == 5'd0) begin
        e_cyc = fw + 3 + mw + 2; e_re = mw + 1; e_pcwe = 1; e_rfwe = rd_nz; e_wsel = 2'd1;
      end else begin
        e_cyc = fw + 3 + mw + 1; e_we = mw + 1; e_pcwe = 1;
      end
    end else begin
      e_cyc = fw + 4; e_pcwe = 1; e_rfwe = rd_nz;
      e_alu = (op == 5'd12) ? 0 : 1;
      e_wsel = (op == 5'd27 || op == 5'd25) ? 2'd2 : 2'd0;
      e_pcsrc = (op == 5'd27) ? 2'd2 : (op == 5'd25) ? 2'd3 : 2'd0;
      case (op)
        5'd4:       e_imm = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 3'd2 : 3'd1;
        5'd25:      e_imm = 3'd1;
        5'd13, 5'd5: e_imm = 3'd5;
        5'd27:      e_imm = 3'd6;
        default:    e_imm = 3'd0;
      endcase
    end

    chk({name, ":cycles"}, n_cyc, e_cyc);
    chk({name, ":pc_we_cnt"}, n_pcwe, e_pcwe);
    chk({name, ":rf_we_cnt"}, n_rfwe, e_rfwe);
    chk({name, ":dmem_re_cnt"}, n_re, e_re);
    chk({name, ":dmem_we_cnt"}, n_we, e_we);
    chk({name, ":ir_we_cnt"}, n_irwe, e_irwe);
    chk({name, ":ir_we_outside_fetch"}, n_irbad, 0);
    chk({name, ":alu_src_imm_cnt"}, n_alu, e_alu);
    chk({name, ":halted"}, 32'(saw_halt), 32'(e_halt));
    chk({name, ":fault"}, 32'(saw_fault), 32'(e_fault));
    if (e_pcwe == 1) begin
      chk({name, ":pc_src"}, 32'(o_pcsrc), 32'(e_pcsrc));
      chk({name, ":imm_type"}, 32'(o_imm), 32'(e_imm));
    end
    if (e_rfwe == 1) chk({name, ":rf_wsel"}, 32'(o_wsel), 32'(e_wsel));
    if (saw_halt || saw_fault) begin
      repeat (2) tick();
      chk({name, ":sticky_state"}, 32'(state), e_halt ? 32'd5 : 32'd6);
      chk({name, ":sticky_imem_req"}, 32'(imem_req), 0);
      do_reset(name);
    end
  endtask

  initial begin
    logic [31:0] r;
    int mw;
    fwait = 0; mwait = 0; fcnt = 0; mcnt = 0;
    do_reset("init");

    run_instr("addi", 32'h0050_0093, 0, 0, 1'b0);
    run_instr("beq_taken", 32'h0020_8463, 0, 0, 1'b1);
    run_instr("beq_not", 32'h0020_8463, 1, 0, 1'b0);
    run_instr("lw_wait3", 32'h0001_2283, 0, 3, 1'b0);
    run_instr("sw_timeout", 32'h0051_2023, 0, 100, 1'b0);
    run_instr("ecall", 32'h0000_0073, 0, 0, 1'b0);
    run_instr("illegal_7f", 32'h0000_007F, 0, 0, 1'b0);
    run_instr("jal_x1", 32'h0080_00EF, 2, 0, 1'b0);
    run_instr("jalr_x0", 32'h0000_8067, 0, 0, 1'b0);
    run_instr("slli", 32'h0011_1093, 0, 0, 1'b0);
    run_instr("fetch_timeout", 32'h0050_0093, 40, 0, 1'b0);

    // Reset landing in the middle of a store's MEM wait.
    do_reset("pre_mid_mem");
    instruction = 32'h0051_2023; fwait = 0; mwait = 100; fcnt = 0; mcnt = 0;
    repeat (4) tick();
    chk("mid_mem:in_mem", {state, dmem_we}, {3'd3, 1'b1});
    @(negedge clk);
    reset = 1'b1;
    dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_mem:after_reset", {state, dmem_we, dmem_re}, {3'd0, 1'b0, 1'b0});

    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      r[6:2] = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 15) != 0) r[1:0] = 2'b11;
      mw = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 4));
      run_instr($sformatf("rand%0d", n), r, int'($urandom_range(0, 3)), mw, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and selects the immediate format for the immediate decoder. It also drives the register-file, PC, ALU-operand and data-memory strobes. It sits between the instruction register and the shared datapath (PC, ALU, register file, immediate decoder, memory port).

Parameters:
MEM_TIMEOUT, 15, max cycles a memory request (FETCH or MEM) may wait for ready before fault; counter width = clog2(MEM_TIMEOUT+1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
instruction  in  32  current IR contents (valid from DECODE onward)
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
branch_taken  in  1  ALU branch comparison result, sampled in EXECUTE
imem_req  out  1  instruction fetch request
ir_we  out  1  load IR from instruction memory
pc_we  out  1  PC update strobe
pc_src  out  2  0=PC+4, 1=branch target, 2=JAL target, 3=JALR target
imm_type  out  3  0=none, 1=I, 2=shamt, 3=S, 4=B, 5=U, 6=J
alu_src_imm  out  1  ALU operand B = immediate
rf_we  out  1  register file write strobe
rf_wsel  out  2  0=ALU, 1=load data, 2=PC+4
dmem_re  out  1  data read request
dmem_we  out  1  data write request
halted  out  1  ECALL/EBREAK reached; sticky until reset
fault  out  1  memory timeout or illegal opcode; sticky until reset
state  out  3  current FSM state, for debug

Behaviour:
- Reset is synchronous, active-high, and wins over every other event.
  - Reset values: state=FETCH; all strobes 0; pc_src=0; imm_type=0; rf_wsel=0; halted=0; fault=0; timeout counter=0.
  - Reset asserted mid-MEM: dmem_re/dmem_we are 0 from the cycle after the reset edge.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, FAULT=6.
- FETCH:
  - imem_req=1 until imem_ready.
  - On imem_ready: ir_we=1 that same cycle (Mealy), then go to DECODE.
  - Otherwise increment the timeout counter; at MEM_TIMEOUT go to FAULT.
- DECODE (exactly 1 cycle):
  - Classify instruction[6:2] and register the class plus imm_type. The registered value is held stable through WB.
  - imm_type mapping by opcode[6:2]:
    - 00000 load, 00100 OP-IMM, 11001 JALR → I.
    - OP-IMM with funct3 = 001 or 101 → shamt.
    - 01000 → S; 11000 → B; 01101/00101 → U; 11011 → J.
    - 01100 OP, 00011 FENCE, 11100 SYSTEM → none.
  - Next state is EXECUTE, except SYSTEM goes to HALT. Unrecognised opcodes are handled per the optional feature.
- EXECUTE (exactly 1 cycle):
  - alu_src_imm=1 for every class except OP and branch.
  - Branch: pc_we=1, pc_src = branch_taken ? 1 : 0, then FETCH.
  - FENCE: pc_we=1, pc_src=0, then FETCH.
  - Load/store: go to MEM.
  - All other classes: go to WB.
- MEM:
  - Load holds dmem_re=1; store holds dmem_we=1. The strobe stays asserted until dmem_ready, inclusive.
  - On dmem_ready: a load goes to WB; a store asserts pc_we=1, pc_src=0 in the same cycle and goes to FETCH.
  - The timeout counter is cleared on entry and increments each waiting cycle. When it equals MEM_TIMEOUT, drop strobes and go to FAULT.
  - dmem_ready outside MEM is ignored.
- WB (exactly 1 cycle):
  - rf_we=1 unless instruction[11:7]==0.
  - rf_wsel: load=1; JAL/JALR=2; otherwise 0.
  - pc_we=1. pc_src: JAL=2, JALR=3, otherwise 0.
  - Then FETCH.
- HALT: halted=1, all strobes 0, stays until reset.
- FAULT: fault=1, all strobes 0, stays until reset.
- At most one pc_we pulse per instruction. ir_we never asserts outside FETCH.
- Latency:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles plus fetch wait.
  - Branch/FENCE: 3 cycles.
  - Load: 5 cycles plus waits. Store: 4 cycles plus waits.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an unrecognised opcode, or instruction[1:0]!=2'b11, goes from DECODE to FAULT with fault=1.
- Undefined: such instructions behave as NOP. DECODE→EXECUTE, then pc_we=1, pc_src=0, then FETCH; imm_type=0; no rf_we; fault is never set by decode.

Test Plan:
- ADDI x1,x0,5 (0x00500093), imem_ready immediate → FETCH,DECODE,EXECUTE,WB; imm_type=1, alu_src_imm=1; WB: rf_we=1, rf_wsel=0, pc_we=1, pc_src=0; 4 cycles total.
- BEQ (0x00208463) with branch_taken=1, then again with 0 → EXECUTE: pc_we=1, pc_src=1 then pc_src=0; imm_type=4; rf_we never asserted.
- LW x5,0(x2) (0x00012283), dmem_ready delayed 3 cycles → dmem_re high 4 cycles; WB: rf_we=1, rf_wsel=1.
- SW (0x00512023), dmem_ready never asserted, MEM_TIMEOUT=15 → dmem_we drops after 15 wait cycles; state=6, fault=1 until reset.
- ECALL (0x00000073) → HALT, halted=1, imem_req=0. Reset pulse → state=0, halted=0, imem_req=1.
- Opcode 0x0000007F with ILLEGAL_TRAP_EN defined → fault=1. Without the macro → pc_we=1, pc_src=0, rf_we=0, back to FETCH.
